// File: rtl/mips_pkg.sv
// Shared types and constants for the parametrised multicycle MIPS datapath.
package mips_pkg;

  typedef enum logic [1:0] {
    SRCB_REG    = 2'b00,
    SRCB_INC    = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_IMM_SH = 2'b11
  } alusrcb_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_RESET  = 2'b11
  } pcsrc_e;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Register-address width for a given register-file depth.
  function automatic int reg_aw(input int nregs);
    return (nregs <= 2) ? 1 : $clog2(nregs);
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port, r0 reads as zero.
module mips_regfile
  import mips_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [reg_aw(NREGS)-1:0]   ra1,
  input  logic [reg_aw(NREGS)-1:0]   ra2,
  input  logic [reg_aw(NREGS)-1:0]   wa,
  input  logic [XLEN-1:0]            wd,
  output logic [XLEN-1:0]            rd1,
  output logic [XLEN-1:0]            rd2
);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (we && (wa != '0)) regs[wa] <= wd;
  end

  assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/mips_datapath_mc.sv
// Multicycle MIPS datapath: PC/IR/MDR/A/B/ALUOut registers, ALU, branch/jump PC update,
// memory-ready stall on instruction and data capture.
module mips_datapath_mc
  import mips_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              NREGS     = 32,
  parameter int              BYTE_ADDR = 0,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] memdata,
  input  logic            mem_ready,
  input  logic            alusrca,
  input  logic [1:0]      alusrcb,
  input  logic            pcwrite,
  input  logic            branch,
  input  logic            branch_ne,
  input  logic [1:0]      pcsource,
  input  logic            memtoreg,
  input  logic            regdst,
  input  logic            iord,
  input  logic            regwrite,
  input  logic            irwrite,
  input  logic            mdrwrite,
  input  logic [2:0]      alucontrol,
  output logic [XLEN-1:0] addr,
  output logic [XLEN-1:0] writedata,
  output logic [5:0]      op,
  output logic [5:0]      funct,
  output logic            zero,
  output logic            mem_stall,
  output logic [XLEN-1:0] pc
);

  localparam int              REG_AW = reg_aw(NREGS);
  localparam logic [XLEN-1:0] PC_INC = (BYTE_ADDR != 0) ? XLEN'(4) : XLEN'(1);

  logic [31:0]       ir_reg;
  logic [XLEN-1:0]   pc_reg, mdr_reg, a_reg, b_reg, aluout_reg;
  logic [XLEN-1:0]   rd1, rd2, imm_ext, imm_sh, jump_target;
  logic [XLEN-1:0]   src_a, src_b, alu_result, pc_next, wb_data;
  logic [REG_AW-1:0] ra1, ra2, wa;
  logic [4:0]        shamt;
  logic              pc_en;
  alusrcb_e          srcb_sel;
  pcsrc_e            pcsrc_sel;

  assign srcb_sel  = alusrcb_e'(alusrcb);
  assign pcsrc_sel = pcsrc_e'(pcsource);

  // Reset suppresses the stall so a controller held in fetch cannot block reset state.
  assign mem_stall = (irwrite | mdrwrite) & ~mem_ready & ~reset;
  assign pc_en     = (pcwrite | (branch & (zero ^ branch_ne))) & ~mem_stall;

  assign ra1     = ir_reg[21 +: REG_AW];
  assign ra2     = ir_reg[16 +: REG_AW];
  assign wa      = regdst ? ir_reg[11 +: REG_AW] : ir_reg[16 +: REG_AW];
  assign wb_data = memtoreg ? mdr_reg : aluout_reg;
  assign shamt   = ir_reg[10:6];

  mips_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
    .clk (clk),
    .we  (regwrite),
    .ra1 (ra1),
    .ra2 (ra2),
    .wa  (wa),
    .wd  (wb_data),
    .rd1 (rd1),
    .rd2 (rd2)
  );

  assign imm_ext = {{(XLEN-16){ir_reg[15]}}, ir_reg[15:0]};
  assign imm_sh  = (BYTE_ADDR != 0) ? (imm_ext << 2) : imm_ext;

  generate
    if (BYTE_ADDR != 0) begin : g_jump_byte
      assign jump_target = {pc_reg[XLEN-1:28], ir_reg[25:0], 2'b00};
    end else begin : g_jump_word
      assign jump_target = {pc_reg[XLEN-1:26], ir_reg[25:0]};
    end
  endgenerate

  always_comb begin
    src_a = alusrca ? a_reg : pc_reg;
    unique case (srcb_sel)
      SRCB_REG:    src_b = b_reg;
      SRCB_INC:    src_b = PC_INC;
      SRCB_IMM:    src_b = imm_ext;
      SRCB_IMM_SH: src_b = imm_sh;
      default:     src_b = b_reg;
    endcase
  end

  always_comb begin
    alu_result = '0;
    case (alucontrol)
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_ADD: alu_result = src_a + src_b;
      ALU_SUB: alu_result = src_a - src_b;
      ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      ALU_SLL: alu_result = src_b << shamt;
      ALU_SRL: alu_result = src_b >> shamt;
      default: alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);

  always_comb begin
    unique case (pcsrc_sel)
      PCSRC_ALU:    pc_next = alu_result;
      PCSRC_ALUOUT: pc_next = aluout_reg;
      PCSRC_JUMP:   pc_next = jump_target;
      PCSRC_RESET:  pc_next = RESET_PC;
      default:      pc_next = alu_result;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg     <= RESET_PC;
      ir_reg     <= '0;
      mdr_reg    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      aluout_reg <= '0;
    end else begin
      a_reg      <= rd1;
      b_reg      <= rd2;
      aluout_reg <= alu_result;
      if (irwrite && mem_ready)  ir_reg  <= memdata[31:0];
      if (mdrwrite && mem_ready) mdr_reg <= memdata;
      if (pc_en)                 pc_reg  <= pc_next;
    end
  end

  assign addr      = iord ? aluout_reg : pc_reg;
  assign writedata = b_reg;
  assign op        = ir_reg[31:26];
  assign funct     = ir_reg[5:0];
  assign pc        = pc_reg;

endmodule

// File: tb/tb_mips_datapath_mc.sv
// Directed bench: three datapath configurations driven through fetch, stall, write-back,
// branch, jump and 64-bit wrap scenarios.
module tb_mips_datapath_mc;
  import mips_pkg::*;

  typedef struct packed {
    logic       mem_ready;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       pcwrite;
    logic       branch;
    logic       branch_ne;
    logic [1:0] pcsource;
    logic       memtoreg;
    logic       regdst;
    logic       iord;
    logic       regwrite;
    logic       irwrite;
    logic       mdrwrite;
    logic [2:0] alucontrol;
  } ctrl_t;

  logic  clk = 1'b0;
  logic  reset = 1'b1;
  ctrl_t c0 = '0, c1 = '0, c2 = '0;
  logic [31:0] md0 = '0, md1 = '0;
  logic [63:0] md2 = '0;
  logic [31:0] addr0, wd0, pc0, addr1, wd1, pc1;
  logic [63:0] addr2, wd2, pc2;
  logic [5:0]  op0, fn0, op1, fn1, op2, fn2;
  logic        z0, z1, z2, st0, st1, st2;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mips_datapath_mc #(.XLEN(32), .NREGS(32), .BYTE_ADDR(1), .RESET_PC(32'h40)) u0 (
    .clk(clk), .reset(reset), .memdata(md0), .mem_ready(c0.mem_ready),
    .alusrca(c0.alusrca), .alusrcb(c0.alusrcb), .pcwrite(c0.pcwrite), .branch(c0.branch),
    .branch_ne(c0.branch_ne), .pcsource(c0.pcsource), .memtoreg(c0.memtoreg),
    .regdst(c0.regdst), .iord(c0.iord), .regwrite(c0.regwrite), .irwrite(c0.irwrite),
    .mdrwrite(c0.mdrwrite), .alucontrol(c0.alucontrol), .addr(addr0), .writedata(wd0),
    .op(op0), .funct(fn0), .zero(z0), .mem_stall(st0), .pc(pc0));

  mips_datapath_mc #(.XLEN(32), .NREGS(32), .BYTE_ADDR(0), .RESET_PC(32'hF000_0000)) u1 (
    .clk(clk), .reset(reset), .memdata(md1), .mem_ready(c1.mem_ready),
    .alusrca(c1.alusrca), .alusrcb(c1.alusrcb), .pcwrite(c1.pcwrite), .branch(c1.branch),
    .branch_ne(c1.branch_ne), .pcsource(c1.pcsource), .memtoreg(c1.memtoreg),
    .regdst(c1.regdst), .iord(c1.iord), .regwrite(c1.regwrite), .irwrite(c1.irwrite),
    .mdrwrite(c1.mdrwrite), .alucontrol(c1.alucontrol), .addr(addr1), .writedata(wd1),
    .op(op1), .funct(fn1), .zero(z1), .mem_stall(st1), .pc(pc1));

  mips_datapath_mc #(.XLEN(64), .NREGS(8), .BYTE_ADDR(0), .RESET_PC(64'h0)) u2 (
    .clk(clk), .reset(reset), .memdata(md2), .mem_ready(c2.mem_ready),
    .alusrca(c2.alusrca), .alusrcb(c2.alusrcb), .pcwrite(c2.pcwrite), .branch(c2.branch),
    .branch_ne(c2.branch_ne), .pcsource(c2.pcsource), .memtoreg(c2.memtoreg),
    .regdst(c2.regdst), .iord(c2.iord), .regwrite(c2.regwrite), .irwrite(c2.irwrite),
    .mdrwrite(c2.mdrwrite), .alucontrol(c2.alucontrol), .addr(addr2), .writedata(wd2),
    .op(op2), .funct(fn2), .zero(z2), .mem_stall(st2), .pc(pc2));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, got, exp);
  endtask

  initial begin
    // Reset; u0 requests a fetch with memory not ready, which must not stall under reset.
    step(); step();
    c0.irwrite = 1'b1;
    #1;
    check("rst_stall", st0, 0);
    check("rst_pc0", pc0, 64'h40);
    check("rst_op", op0, 0);
    check("rst_funct", fn0, 0);
    check("rst_wdata", wd0, 0);
    check("rst_addr", addr0, 64'h40);
    check("rst_pc1", pc1, 64'hF000_0000);
    check("rst_pc2", pc2, 0);

    // Fetch with three not-ready cycles.
    reset = 1'b0;
    c0.pcwrite = 1'b1; c0.alusrcb = 2'b01; c0.alucontrol = ALU_ADD;
    md0 = 32'h8C00_0025;
    #1;
    check("stall_on", st0, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", pc0, 64'h40);
      check("stall_ir", op0, 0);
    end
    c0.mem_ready = 1'b1;
    #1;
    check("stall_off", st0, 0);
    step();
    check("fetch_op", op0, 6'h23);
    check("fetch_funct", fn0, 6'h25);
    check("fetch_pc", pc0, 64'h44);

    // r0 write is discarded.
    c0.irwrite = 1'b0; c0.pcwrite = 1'b0;
    c0.mdrwrite = 1'b1; md0 = 32'h0000_DEAD;
    step();
    c0.mdrwrite = 1'b0; c0.regwrite = 1'b1; c0.regdst = 1'b1; c0.memtoreg = 1'b1;
    step();
    c0.regwrite = 1'b0;
    step();
    check("r0_zero", wd0, 0);

    // Fetch rs=rt=rd=3, write r3 from MDR.
    c0.irwrite = 1'b1; c0.pcwrite = 1'b1; md0 = 32'h0063_1820;
    step();
    check("fetch2_pc", pc0, 64'h48);
    check("fetch2_funct", fn0, 6'h20);
    c0.irwrite = 1'b0; c0.pcwrite = 1'b0; c0.regwrite = 1'b1;
    step();
    c0.regwrite = 1'b0;
    step();
    check("r3_wb", wd0, 64'hDEAD);
    c0.alusrca = 1'b1; c0.alusrcb = 2'b00; c0.alucontrol = ALU_SUB;
    #1;
    check("a_eq_b", z0, 1);
    c0.alusrcb = 2'b01; c0.alucontrol = ALU_ADD;
    #1;
    check("a_plus4_nz", z0, 0);
    step();
    c0.iord = 1'b1;
    #1;
    check("aluout_a4", addr0, 64'hDEB1);
    c0.iord = 1'b0;

    // Load r5=5 and fetch BEQ r5,r5,-2.
    c0.mdrwrite = 1'b1; md0 = 32'h5;
    step();
    c0.mdrwrite = 1'b0;
    c0.irwrite = 1'b1; c0.pcwrite = 1'b1; c0.alusrca = 1'b0; c0.alusrcb = 2'b01;
    c0.alucontrol = ALU_ADD; c0.pcsource = 2'b00; md0 = 32'h10A5_FFFE;
    step();
    check("beq_fetch_pc", pc0, 64'h4C);
    check("beq_op", op0, 6'h04);
    c0.irwrite = 1'b0; c0.pcwrite = 1'b0;
    c0.regwrite = 1'b1; c0.regdst = 1'b0; c0.memtoreg = 1'b1; c0.alusrcb = 2'b11;
    step();
    c0.regwrite = 1'b0;
    step();
    check("r5_wb", wd0, 64'h5);
    c0.iord = 1'b1;
    #1;
    check("br_target", addr0, 64'h44);
    c0.iord = 1'b0;
    c0.alusrca = 1'b1; c0.alusrcb = 2'b00; c0.alucontrol = ALU_SUB;
    c0.branch = 1'b1; c0.branch_ne = 1'b1; c0.pcsource = 2'b01;
    #1;
    check("beq_zero", z0, 1);
    step();
    check("bne_not_taken", pc0, 64'h4C);
    c0.branch = 1'b0; c0.branch_ne = 1'b0;
    step();
    check("zero_alone", pc0, 64'h4C);
    c0.alusrca = 1'b0; c0.alusrcb = 2'b11; c0.alucontrol = ALU_ADD;
    step();
    c0.alusrca = 1'b1; c0.alusrcb = 2'b00; c0.alucontrol = ALU_SUB; c0.branch = 1'b1;
    step();
    check("beq_taken", pc0, 64'h44);
    c0.branch = 1'b0;

    // Jump on byte-addressed PC, then increment and RESET_PC select.
    c0.irwrite = 1'b1; c0.pcwrite = 1'b1; c0.alusrca = 1'b0; c0.alusrcb = 2'b01;
    c0.alucontrol = ALU_ADD; c0.pcsource = 2'b00; md0 = 32'h0800_0010;
    step();
    check("j_fetch_pc", pc0, 64'h48);
    c0.irwrite = 1'b0; c0.pcsource = 2'b10;
    step();
    check("jump_byte", pc0, 64'h40);
    c0.pcsource = 2'b00;
    step();
    check("pc_inc4", pc0, 64'h44);
    c0.pcsource = 2'b11;
    step();
    check("pc_resetsel", pc0, 64'h40);
    c0.pcwrite = 1'b0;

    // Word-addressed jump keeps PC[31:26].
    c1.mem_ready = 1'b1; c1.irwrite = 1'b1; c1.pcwrite = 1'b1; c1.alusrcb = 2'b01;
    c1.alucontrol = ALU_ADD; md1 = 32'h0800_0010;
    step();
    check("u1_inc1", pc1, 64'hF000_0001);
    c1.irwrite = 1'b0; c1.pcsource = 2'b10;
    step();
    check("jump_word", pc1, 64'hF000_0010);
    c1.pcwrite = 1'b0;

    // 64-bit, 8 registers: rd=rt=9 truncates to r1; all-ones + 1 wraps to 0.
    c2.mem_ready = 1'b1; c2.irwrite = 1'b1; c2.pcwrite = 1'b1; c2.alusrcb = 2'b01;
    c2.alucontrol = ALU_ADD; md2 = 64'h0000_0000_0029_4820;
    step();
    check("u2_pc", pc2, 64'h1);
    c2.irwrite = 1'b0; c2.pcwrite = 1'b0;
    c2.mdrwrite = 1'b1; md2 = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    check("u2_mdr_hold_ir", fn2, 6'h20);
    c2.mdrwrite = 1'b0; c2.regwrite = 1'b1; c2.regdst = 1'b1; c2.memtoreg = 1'b1;
    step();
    c2.regwrite = 1'b0;
    step();
    check("r9_to_r1", wd2, 64'hFFFF_FFFF_FFFF_FFFF);
    c2.alusrca = 1'b1; c2.alusrcb = 2'b01;
    #1;
    check("wrap_zero", z2, 1);
    step();
    c2.iord = 1'b1;
    #1;
    check("wrap_aluout", addr2, 0);
    c2.alusrcb = 2'b00;
    #1;
    check("sum_nz", z2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
